// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator to a word-addressed data memory; sub-word stores are read-modify-write.
// Latency from accept: load/SW 2, SB/SH 3, error 1. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_mem_initiator #(
    parameter int DEPTH_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    logic [2:0]  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] rdata_q;

    logic        illegal;
    logic        oob;
    logic        misal;
    logic        bad_req;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request checks are made on the live request, before anything is latched.
    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = (req_funct3 > 3'd2);
        else
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end

    assign oob = (req_addr[31:2] >= DEPTH_W);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign bad_req = illegal || oob || misal;

    // Load extraction works on the raw memory word so the result can be registered on the READ edge.
    always_comb begin
        load_ext = mem_read_data;
        case (funct3_q)
            3'd0, 3'd4: begin
                case (addr_q[1:0])
                    2'd0:    load_ext = {24'd0, mem_read_data[7:0]};
                    2'd1:    load_ext = {24'd0, mem_read_data[15:8]};
                    2'd2:    load_ext = {24'd0, mem_read_data[23:16]};
                    default: load_ext = {24'd0, mem_read_data[31:24]};
                endcase
                if (funct3_q == 3'd0)
                    load_ext[31:8] = {24{load_ext[7]}};
            end
            3'd1, 3'd5: begin
                load_ext = addr_q[1] ? {16'd0, mem_read_data[31:16]}
                                     : {16'd0, mem_read_data[15:0]};
                if (funct3_q == 3'd1)
                    load_ext[31:16] = {16{load_ext[15]}};
            end
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        merged = rbuf;
        case (funct3_q)
            3'd0: begin
                case (addr_q[1:0])
                    2'd0:    merged = {rbuf[31:8], wdata_q[7:0]};
                    2'd1:    merged = {rbuf[31:16], wdata_q[7:0], rbuf[7:0]};
                    2'd2:    merged = {rbuf[31:24], wdata_q[7:0], rbuf[15:0]};
                    default: merged = {wdata_q[7:0], rbuf[23:0]};
                endcase
            end
            3'd1:    merged = addr_q[1] ? {wdata_q[15:0], rbuf[15:0]}
                                        : {rbuf[31:16], wdata_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rbuf     <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            // rdata_q is nonzero only in the cycle following a load's READ, i.e. in RESP.
            rdata_q <= ((state == S_READ) && !we_q) ? load_ext : 32'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (bad_req)
                            state <= S_ERR;
                        else if (req_we && (req_funct3 == 3'd2))
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    rbuf  <= mem_read_data;
                    state <= we_q ? S_WRITE : S_RESP;
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = !reset && ((state == S_RESP) || (state == S_ERR));
    assign resp_err       = !reset && (state == S_ERR);
    assign resp_rdata     = rdata_q;
    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign mem_read_en    = !reset && (state == S_READ);
    assign mem_write_en   = !reset && (state == S_WRITE);
    assign mem_write_data = (state == S_WRITE) ? merged : 32'd0;

endmodule
